// File: rtl/led_ctr_if.sv
// Bundle for the two-digit display driver: binary count in, active-low segment codes out.
// The master drives the count; the slave is the display driver that returns the segments.
interface led_ctr_if;
    logic [4:0] state;
    logic [6:0] hex0;
    logic [6:0] hex1;

    modport master (
        output state,
        input  hex0,
        input  hex1
    );

    modport slave (
        input  state,
        output hex0,
        output hex1
    );
endinterface

// File: rtl/led_ctr.sv
// Two-digit seven-segment driver for a 0-19 count: binary to tens/ones, active-low, registered.
// Build option LEDCTR_BLANK_EN: blank the tens digit for counts 0-9 instead of showing "0".
module led_ctr (
    input  logic       clk,
    input  logic       rst_n,
    led_ctr_if.slave   bus
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

    logic       in_range;
    logic       tens;
    logic [3:0] ones;
    logic [6:0] next_hex0;
    logic [6:0] next_hex1;

    always_comb begin
        in_range = (bus.state < 5'd20);
        tens     = (bus.state >= 5'd10);
        // Mod-16 subtract on the low nibble gives the correct ones digit for 10-19
        // (16-19 wrap to 6-9), so the MSB of state is not needed.
        ones     = bus.state[3:0] - (tens ? 4'd10 : 4'd0);

        next_hex0 = SEG_DASH;
        next_hex1 = SEG_DASH;
        if (in_range) begin
            next_hex0 = seg_code(ones);
            if (tens) begin
                next_hex1 = seg_code(4'd1);
            end else begin
`ifdef LEDCTR_BLANK_EN
                next_hex1 = SEG_BLANK;
`else
                next_hex1 = seg_code(4'd0);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.hex0 <= SEG_BLANK;
            bus.hex1 <= SEG_BLANK;
        end else begin
            bus.hex0 <= next_hex0;
            bus.hex1 <= next_hex1;
        end
    end

endmodule

// File: tb/tb_led_ctr.sv
// Bench for led_ctr: directed steps plus random counts, checked against an arithmetic
// model (divide/modulo by 10 and a digit table) of the expected display.
module tb_led_ctr;

    logic clk;
    logic rst_n;

    led_ctr_if bus ();

    led_ctr dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [6:0] exp0;
    logic [6:0] exp1;

    task automatic model(input int s, input bit in_rst, output logic [6:0] e0, output logic [6:0] e1);
        int t;
        int o;
        if (in_rst) begin
            e0 = 7'h7F;
            e1 = 7'h7F;
        end else if (s > 19) begin
            e0 = 7'h3F;
            e1 = 7'h3F;
        end else begin
            t  = s / 10;
            o  = s % 10;
            e0 = seg_tab[o];
            if (t == 1)
                e1 = seg_tab[1];
            else begin
`ifdef LEDCTR_BLANK_EN
                e1 = 7'h7F;
`else
                e1 = seg_tab[0];
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Drive on the falling edge, then check both outputs just after the next rising edge.
    task automatic step(input int s, input bit rst_lo, input string tag);
        @(negedge clk);
        bus.state = s[4:0];
        rst_n     = ~rst_lo;
        @(posedge clk);
        #1;
        model(s, rst_lo, exp0, exp1);
        check({tag, ".hex0"}, bus.hex0, exp0);
        check({tag, ".hex1"}, bus.hex1, exp1);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.state = 5'd7;

        step(7, 1, "reset0");
        step(7, 1, "reset1");
        step(7, 0, "release");

        for (int s = 0; s < 20; s++) begin
            if (s == 15) begin
                step(15, 1, "midreset");
                step(15, 0, "resume");
            end else begin
                step(s, 0, $sformatf("sweep%0d", s));
            end
        end

        step(9,  0, "bound9");
        step(10, 0, "bound10");
        step(19, 0, "bound19");
        step(20, 0, "oor20");
        step(31, 0, "oor31");
        step(5,  0, "after_oor");

        // Latency: output still shows the old digit between edges.
        step(3, 0, "lat3");
        @(negedge clk);
        bus.state = 5'd4;
        #1;
        check("lat_hold.hex0", bus.hex0, 7'h30);
        @(posedge clk);
        #1;
        check("lat_new.hex0", bus.hex0, 7'h19);

        for (int i = 0; i < 300; i++) begin
            int  s;
            bit  r;
            s = $urandom_range(0, 31);
            r = ($urandom_range(0, 15) == 0);
            step(s, r, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
